// File: rtl/gobang_pkg.sv
// Shared definitions for the gobang AI search blocks.
//   - board geometry (15x15, row-major cell index = row*15+col)
//   - score width and the "no score yet" sentinel
//   - cell codes, board type, move-selector FSM states
//   - stone_of(): maps the side to move onto the stone it places
package gobang_pkg;

  localparam int CELLS   = 225;
  localparam int POS_W   = 8;
  localparam int SCORE_W = 32;

  // Most negative score; any real score that beats it becomes the best.
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  // Best position reported when no candidate was ever scored.
  localparam logic [POS_W-1:0] NO_POS = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BLACK = 2'd1,
    WHITE = 2'd2
  } cell_t;

  typedef cell_t board_t [CELLS];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Turn 0 is black to move, turn 1 is white to move.
  function automatic cell_t stone_of(input logic turn);
    return turn ? WHITE : BLACK;
  endfunction

endpackage

// File: rtl/eval_board_reg.sv
// Working copy of the board that the Score block evaluates.
//   clk, rst     : clock, synchronous active-high reset (clears to all EMPTY)
//   load         : copy load_board into every cell
//   place        : write place_cell at place_pos
//   restore      : write EMPTY at restore_pos (wins over place on the same cell)
//   board        : packed view, cell i at bits [2i+1:2i]
module eval_board_reg
  import gobang_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [2*CELLS-1:0]   load_board,
  input  logic                 place,
  input  logic [POS_W-1:0]     place_pos,
  input  cell_t                place_cell,
  input  logic                 restore,
  input  logic [POS_W-1:0]     restore_pos,
  output logic [2*CELLS-1:0]   board
);

  board_t cells_reg;

  // One small register per cell so every cell decodes its own write enables.
  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    always_ff @(posedge clk) begin
      if (rst) begin
        cells_reg[gi] <= EMPTY;
      end else if (load) begin
        cells_reg[gi] <= cell_t'(load_board[2*gi +: 2]);
      end else if (restore && (restore_pos == POS_W'(gi))) begin
        cells_reg[gi] <= EMPTY;
      end else if (place && (place_pos == POS_W'(gi))) begin
        cells_reg[gi] <= place_cell;
      end
    end

    assign board[2*gi +: 2] = cells_reg[gi];
  end

endmodule

// File: rtl/move_selector.sv
// Walks a stream of candidate moves, scores each one with the external Score
// block and keeps the best.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_start               : one-cycle request, captures i_board / i_turn
//   i_cand_*/o_cand_ready : candidate stream (pos, last marker)
//   o_sc_start/o_sc_board/o_sc_turn, i_sc_score/i_sc_finish : Score handshake
//   o_best_pos/score/valid: running best, stable from o_done to next start
//   o_busy, o_done, o_err : status; o_err is a sticky timeout flag
module move_selector
  import gobang_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [2*CELLS-1:0]        i_board,
  input  logic                      i_turn,
  input  logic                      i_cand_valid,
  output logic                      o_cand_ready,
  input  logic [POS_W-1:0]          i_cand_pos,
  input  logic                      i_cand_last,
  output logic                      o_sc_start,
  output logic [2*CELLS-1:0]        o_sc_board,
  output logic                      o_sc_turn,
  input  logic signed [SCORE_W-1:0] i_sc_score,
  input  logic                      i_sc_finish,
  output logic [POS_W-1:0]          o_best_pos,
  output logic signed [SCORE_W-1:0] o_best_score,
  output logic                      o_best_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t                      state_reg, state_next;
  logic [CNT_W-1:0]            wait_cnt_reg;
  logic                        turn_reg;
  logic [POS_W-1:0]            pos_reg;
  logic                        last_reg;
  logic [POS_W-1:0]            best_pos_reg;
  logic signed [SCORE_W-1:0]   best_score_reg;
  logic                        best_valid_reg;
  logic                        err_reg;

  logic [2*CELLS-1:0]          work_board;
  logic [8:0]                  cand_bit;
  logic [1:0]                  cand_cell;
  logic                        cand_ok;
  logic                        finish_hit;
  logic                        timeout_hit;
  logic                        board_load;
  logic                        board_place;
  logic                        board_restore;

  // Candidate qualification: in range and currently empty on the working board.
  always_comb begin
    cand_bit  = {i_cand_pos, 1'b0};
    cand_cell = work_board[cand_bit +: 2];
    cand_ok   = (i_cand_pos < POS_W'(CELLS)) && (cand_cell == 2'b00);
  end

  // A finish arriving on the last counted cycle still counts as a finish.
  assign finish_hit  = (state_reg == ST_WAIT) && i_sc_finish;
  assign timeout_hit = (state_reg == ST_WAIT) && !i_sc_finish &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_cand_valid) begin
          if (cand_ok)          state_next = ST_START;
          else if (i_cand_last) state_next = ST_DONE;
        end
      end
      ST_START: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (finish_hit)       state_next = last_reg ? ST_DONE : ST_FETCH;
        else if (timeout_hit) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs and datapath strobes decoded from the current state
  always_comb begin
    o_cand_ready  = (state_reg == ST_FETCH);
    o_sc_start    = (state_reg == ST_START);
    o_done        = (state_reg == ST_DONE);
    o_busy        = (state_reg != ST_IDLE);
    board_load    = (state_reg == ST_IDLE) && i_start;
    board_place   = (state_reg == ST_FETCH) && i_cand_valid && cand_ok;
    board_restore = finish_hit || timeout_hit;
  end

  eval_board_reg u_board (
    .clk         (i_clk),
    .rst         (i_rst),
    .load        (board_load),
    .load_board  (i_board),
    .place       (board_place),
    .place_pos   (i_cand_pos),
    .place_cell  (stone_of(turn_reg)),
    .restore     (board_restore),
    .restore_pos (pos_reg),
    .board       (work_board)
  );

  // Request context, best tracker, timeout counter, error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      turn_reg       <= 1'b0;
      pos_reg        <= '0;
      last_reg       <= 1'b0;
      best_pos_reg   <= NO_POS;
      best_score_reg <= SCORE_MIN;
      best_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      wait_cnt_reg   <= '0;
    end else begin
      if (board_load) begin
        turn_reg       <= i_turn;
        best_pos_reg   <= NO_POS;
        best_score_reg <= SCORE_MIN;
        best_valid_reg <= 1'b0;
        err_reg        <= 1'b0;
      end
      if (board_place) begin
        pos_reg  <= i_cand_pos;
        last_reg <= i_cand_last;
      end
      // Strictly greater: on a tie the earlier candidate is kept.
      if (finish_hit && (i_sc_score > best_score_reg)) begin
        best_pos_reg   <= pos_reg;
        best_score_reg <= i_sc_score;
        best_valid_reg <= 1'b1;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
      wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + 1'b1 : '0;
    end
  end

  assign o_sc_board   = work_board;
  assign o_sc_turn    = turn_reg;
  assign o_best_pos   = best_pos_reg;
  assign o_best_score = best_score_reg;
  assign o_best_valid = best_valid_reg;
  assign o_err        = err_reg;

endmodule

// File: tb/tb_move_selector.sv
module tb_move_selector;
  import gobang_pkg::*;

  localparam int TMO = 1024;
  localparam int BW  = 2*CELLS;
  typedef logic signed [SCORE_W-1:0] score_t;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [BW-1:0]     i_board = '0;
  logic              i_turn = 1'b0;
  logic              i_cand_valid = 1'b0;
  logic              o_cand_ready;
  logic [POS_W-1:0]  i_cand_pos = '0;
  logic              i_cand_last = 1'b0;
  logic              o_sc_start;
  logic [BW-1:0]     o_sc_board;
  logic              o_sc_turn;
  score_t            i_sc_score = '0;
  logic              i_sc_finish = 1'b0;
  logic [POS_W-1:0]  o_best_pos;
  score_t            o_best_score;
  logic              o_best_valid;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  move_selector #(.TIMEOUT_CYC(TMO)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_board      (i_board),
    .i_turn       (i_turn),
    .i_cand_valid (i_cand_valid),
    .o_cand_ready (o_cand_ready),
    .i_cand_pos   (i_cand_pos),
    .i_cand_last  (i_cand_last),
    .o_sc_start   (o_sc_start),
    .o_sc_board   (o_sc_board),
    .o_sc_turn    (o_sc_turn),
    .i_sc_score   (i_sc_score),
    .i_sc_finish  (i_sc_finish),
    .o_best_pos   (o_best_pos),
    .o_best_score (o_best_score),
    .o_best_valid (o_best_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Stimulus for one request: candidates in order, and for each scored
  // candidate (in sc_start order) its stub score and latency (-1 = never).
  int     q_pos[$];
  bit     q_last[$];
  score_t q_score[$];
  int     q_lat[$];

  // Observations recorded by the session driver.
  int            n_starts, start_cyc, done_cyc, wait_entry_cyc;
  bit            done_seen, done_next, err_d, err_fetch, valid_d;
  int            pos_d;
  score_t        score_d;
  logic [BW-1:0] board_d;
  logic [BW-1:0] wait_boards[$];
  logic          wait_turns[$];

  // Drives one request and behaves as the Score stub; no checking here.
  task automatic run_session(input logic [BW-1:0] board, input logic turn);
    int  idx = 0;
    int  sidx = 0;
    int  k = 0;
    bit  in_wait;
    n_starts = 0;
    done_seen = 0;
    done_next = 0;
    wait_boards.delete();
    wait_turns.delete();
    @(negedge clk);
    i_start = 1'b1;
    i_board = board;
    i_turn  = turn;
    start_cyc = cyc;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c == 0) err_fetch = o_err;
      if (o_done) begin
        done_seen = 1;
        done_cyc  = cyc;
        pos_d     = int'(o_best_pos);
        score_d   = o_best_score;
        valid_d   = o_best_valid;
        err_d     = o_err;
        board_d   = o_sc_board;
        i_cand_valid = 1'b0;
        i_sc_finish  = 1'b0;
        break;
      end
      if (o_sc_start) begin
        n_starts++;
        k = 0;
      end
      in_wait = o_busy && !o_cand_ready && !o_sc_start && !o_done;
      if (in_wait) begin
        if (k == 0) begin
          wait_entry_cyc = cyc;
          wait_boards.push_back(o_sc_board);
          wait_turns.push_back(o_sc_turn);
        end
        if (sidx < q_lat.size() && k == q_lat[sidx]) begin
          i_sc_finish = 1'b1;
          i_sc_score  = q_score[sidx];
          sidx++;
        end else begin
          i_sc_finish = 1'b0;
        end
        k++;
      end else begin
        i_sc_finish = 1'b0;
      end
      if (o_cand_ready && idx < q_pos.size()) begin
        i_cand_valid = 1'b1;
        i_cand_pos   = POS_W'(q_pos[idx]);
        i_cand_last  = q_last[idx];
        idx++;
      end else begin
        i_cand_valid = 1'b0;
      end
      @(negedge clk);
    end
    i_cand_valid = 1'b0;
    i_sc_finish  = 1'b0;
    if (done_seen) begin
      @(negedge clk);
      done_next = o_done;
    end
  endtask

  task automatic clear_queues();
    q_pos.delete(); q_last.delete(); q_score.delete(); q_lat.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", o_busy); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", o_done); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", o_err); end
    checks++; if (o_sc_start !== 1'b0) begin failures++; $display("FAIL reset_sc_start got=%0b exp=0", o_sc_start); end
    checks++; if (o_cand_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", o_cand_ready); end
    checks++; if (o_best_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_best_valid); end
    checks++; if (o_best_pos !== 8'd255) begin failures++; $display("FAIL reset_pos got=%0d exp=255", o_best_pos); end
    checks++; if (o_best_score !== SCORE_MIN) begin failures++; $display("FAIL reset_score got=%0d exp=%0d", o_best_score, SCORE_MIN); end
    checks++; if (o_sc_board !== '0) begin failures++; $display("FAIL reset_board got=%h exp=0", o_sc_board); end
    checks++; if (o_sc_turn !== 1'b0) begin failures++; $display("FAIL reset_turn got=%0b exp=0", o_sc_turn); end
    i_rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    clear_queues();
    q_pos = '{112, 113, 97};
    q_last = '{0, 0, 1};
    q_score = '{score_t'(10), score_t'(50), score_t'(50)};
    q_lat = '{2, 0, 3};
    run_session('0, 1'b0);
    checks++; if (!done_seen) begin failures++; $display("FAIL basic_done got=timeout exp=done"); end
    checks++; if (n_starts !== 3) begin failures++; $display("FAIL basic_starts got=%0d exp=3", n_starts); end
    checks++; if (pos_d !== 113) begin failures++; $display("FAIL basic_pos got=%0d exp=113", pos_d); end
    checks++; if (score_d !== score_t'(50)) begin failures++; $display("FAIL basic_score got=%0d exp=50", score_d); end
    checks++; if (valid_d !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", valid_d); end
    checks++; if (done_cyc - start_cyc !== 15) begin failures++; $display("FAIL basic_latency got=%0d exp=15", done_cyc - start_cyc); end
    checks++; if (done_next !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%0b exp=0", done_next); end
    checks++; if (board_d !== '0) begin failures++; $display("FAIL basic_restore got=%h exp=0", board_d); end
    $display("basic: starts=%0d best_pos=%0d best_score=%0d", n_starts, pos_d, score_d);
  endtask

  task automatic test_skip();
    logic [BW-1:0] b;
    b = '0;
    b[2*7 +: 2] = 2'd2;
    clear_queues();
    q_pos = '{7, 230, 40};
    q_last = '{0, 0, 1};
    q_score = '{score_t'(-5)};
    q_lat = '{1};
    run_session(b, 1'b0);
    checks++; if (!done_seen) begin failures++; $display("FAIL skip_done got=timeout exp=done"); end
    checks++; if (n_starts !== 1) begin failures++; $display("FAIL skip_starts got=%0d exp=1", n_starts); end
    checks++; if (pos_d !== 40) begin failures++; $display("FAIL skip_pos got=%0d exp=40", pos_d); end
    checks++; if (score_d !== score_t'(-5)) begin failures++; $display("FAIL skip_score got=%0d exp=-5", score_d); end
    if (wait_boards.size() > 0) begin
      checks++; if (wait_boards[0][81:80] !== 2'd1) begin failures++; $display("FAIL skip_stone got=%0d exp=1", wait_boards[0][81:80]); end
    end else begin
      checks++; failures++; $display("FAIL skip_wait_seen got=0 exp=1");
    end
    checks++; if (board_d !== b) begin failures++; $display("FAIL skip_restore got=%h exp=%h", board_d, b); end
    checks++; if (done_cyc - start_cyc !== 1 + 1 + 1 + 4) begin failures++; $display("FAIL skip_latency got=%0d exp=7", done_cyc - start_cyc); end
    $display("skip: starts=%0d best_pos=%0d best_score=%0d", n_starts, pos_d, score_d);
  endtask

  task automatic test_none();
    logic [BW-1:0] b;
    b = '0;
    b[1:0] = 2'd1;
    clear_queues();
    q_pos = '{0};
    q_last = '{1};
    run_session(b, 1'b1);
    checks++; if (!done_seen) begin failures++; $display("FAIL none_done got=timeout exp=done"); end
    checks++; if (done_cyc - start_cyc !== 2) begin failures++; $display("FAIL none_latency got=%0d exp=2", done_cyc - start_cyc); end
    checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL none_valid got=%0b exp=0", valid_d); end
    checks++; if (pos_d !== 255) begin failures++; $display("FAIL none_pos got=%0d exp=255", pos_d); end
    checks++; if (score_d !== SCORE_MIN) begin failures++; $display("FAIL none_score got=%0d exp=%0d", score_d, SCORE_MIN); end
    checks++; if (n_starts !== 0) begin failures++; $display("FAIL none_starts got=%0d exp=0", n_starts); end
    $display("none: starts=%0d best_valid=%0b", n_starts, valid_d);
  endtask

  task automatic test_timeout();
    clear_queues();
    q_pos = '{50};
    q_last = '{1};
    q_score = '{score_t'(9)};
    q_lat = '{-1};
    run_session('0, 1'b1);
    checks++; if (!done_seen) begin failures++; $display("FAIL tmo_done got=timeout exp=done"); end
    checks++; if (done_cyc - wait_entry_cyc !== TMO) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", done_cyc - wait_entry_cyc, TMO); end
    checks++; if (err_d !== 1'b1) begin failures++; $display("FAIL tmo_err got=%0b exp=1", err_d); end
    checks++; if (board_d !== '0) begin failures++; $display("FAIL tmo_restore got=%h exp=0", board_d); end
    checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL tmo_valid got=%0b exp=0", valid_d); end
    repeat (3) @(negedge clk);
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%0b exp=1", o_err); end
    $display("timeout: wait_cycles=%0d err=%0b", done_cyc - wait_entry_cyc, err_d);
    clear_queues();
    q_pos = '{60};
    q_last = '{1};
    q_score = '{score_t'(3)};
    q_lat = '{0};
    run_session('0, 1'b0);
    checks++; if (err_fetch !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%0b exp=0", err_fetch); end
    checks++; if (pos_d !== 60 || score_d !== score_t'(3)) begin failures++; $display("FAIL tmo_next got=%0d/%0d exp=60/3", pos_d, score_d); end
    $display("after timeout: err=%0b best_pos=%0d", err_d, pos_d);
  endtask

  task automatic test_reset_mid_wait();
    int done_pulses = 0;
    @(negedge clk);
    i_start = 1'b1; i_board = '0; i_turn = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_cand_valid = 1'b1; i_cand_pos = 8'd20; i_cand_last = 1'b1;
    @(negedge clk);
    i_cand_valid = 1'b0;
    @(negedge clk);
    // now in WAIT; a start request here must be ignored
    i_start = 1'b1; i_turn = 1'b0; i_board = '1;
    @(negedge clk);
    i_start = 1'b0;
    checks++; if (o_sc_turn !== 1'b1) begin failures++; $display("FAIL busy_start_turn got=%0b exp=1", o_sc_turn); end
    checks++; if (o_sc_board[41:40] !== 2'd2 || o_sc_board[1:0] !== 2'd0) begin failures++; $display("FAIL busy_start_board got=%0d/%0d exp=2/0", o_sc_board[41:40], o_sc_board[1:0]); end
    checks++; if (o_busy !== 1'b1 || o_cand_ready !== 1'b0) begin failures++; $display("FAIL busy_state got=%0b%0b exp=10", o_busy, o_cand_ready); end
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin failures++; $display("FAIL rst_status got=%0b%0b%0b exp=000", o_busy, o_done, o_err); end
    checks++; if (o_sc_start !== 1'b0 || o_cand_ready !== 1'b0) begin failures++; $display("FAIL rst_hs got=%0b%0b exp=00", o_sc_start, o_cand_ready); end
    checks++; if (o_best_pos !== 8'd255 || o_best_score !== SCORE_MIN || o_best_valid !== 1'b0) begin failures++; $display("FAIL rst_best got=%0d/%0d/%0b exp=255/%0d/0", o_best_pos, o_best_score, o_best_valid, SCORE_MIN); end
    checks++; if (o_sc_board !== '0 || o_sc_turn !== 1'b0) begin failures++; $display("FAIL rst_board got=%h/%0b exp=0/0", o_sc_board, o_sc_turn); end
    i_sc_finish = 1'b1; i_sc_score = score_t'(100);
    @(negedge clk);
    i_sc_finish = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (o_done) done_pulses++;
      @(negedge clk);
    end
    checks++; if (done_pulses !== 0) begin failures++; $display("FAIL late_finish_done got=%0d exp=0", done_pulses); end
    checks++; if (o_best_valid !== 1'b0 || o_best_score !== SCORE_MIN || o_busy !== 1'b0) begin failures++; $display("FAIL late_finish_best got=%0b/%0d/%0b exp=0/%0d/0", o_best_valid, o_best_score, o_busy, SCORE_MIN); end
    $display("reset mid-wait: done_pulses=%0d", done_pulses);
  endtask

  task automatic test_random();
    for (int s = 0; s < 20; s++) begin
      logic [BW-1:0] b;
      logic          turn;
      int            n, exp_pos, exp_cost, exp_starts;
      score_t        exp_score, sc;
      bit            exp_valid;
      logic [BW-1:0] exp_wb[$];
      logic [BW-1:0] wb;
      int            p;
      b = '0;
      for (int i = 0; i < CELLS; i++) begin
        int r = int'($urandom_range(0, 9));
        if (r < 2) b[2*i +: 2] = 2'd1;
        else if (r < 4) b[2*i +: 2] = 2'd2;
      end
      turn = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 8));
      clear_queues();
      exp_pos = 255; exp_score = SCORE_MIN; exp_valid = 0;
      exp_cost = 1; exp_starts = 0; exp_wb.delete();
      for (int i = 0; i < n; i++) begin
        p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(225, 255)) : int'($urandom_range(0, 224));
        q_pos.push_back(p);
        q_last.push_back(i == n - 1);
        if (p < CELLS && b[2*p +: 2] == 2'd0) begin
          int lat = int'($urandom_range(0, 4));
          case ($urandom_range(0, 7))
            0:       sc = SCORE_MIN;
            1, 2, 3: sc = score_t'(int'($urandom_range(0, 6)) - 3);
            default: sc = score_t'($urandom);
          endcase
          q_score.push_back(sc);
          q_lat.push_back(lat);
          exp_starts++;
          exp_cost += 3 + lat;
          wb = b;
          wb[2*p +: 2] = turn ? 2'd2 : 2'd1;
          exp_wb.push_back(wb);
          if (sc > exp_score) begin
            exp_score = sc; exp_pos = p; exp_valid = 1;
          end
        end else begin
          exp_cost += 1;
        end
      end
      run_session(b, turn);
      checks++; if (!done_seen) begin failures++; $display("FAIL rnd%0d_done got=timeout exp=done", s); end
      checks++; if (n_starts !== exp_starts) begin failures++; $display("FAIL rnd%0d_starts got=%0d exp=%0d", s, n_starts, exp_starts); end
      checks++; if (pos_d !== exp_pos) begin failures++; $display("FAIL rnd%0d_pos got=%0d exp=%0d", s, pos_d, exp_pos); end
      checks++; if (score_d !== exp_score) begin failures++; $display("FAIL rnd%0d_score got=%0d exp=%0d", s, score_d, exp_score); end
      checks++; if (valid_d !== exp_valid) begin failures++; $display("FAIL rnd%0d_valid got=%0b exp=%0b", s, valid_d, exp_valid); end
      checks++; if (done_cyc - start_cyc !== exp_cost) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", s, done_cyc - start_cyc, exp_cost); end
      checks++; if (board_d !== b) begin failures++; $display("FAIL rnd%0d_restore got=%h exp=%h", s, board_d, b); end
      checks++; if (wait_boards.size() !== exp_wb.size()) begin failures++; $display("FAIL rnd%0d_waits got=%0d exp=%0d", s, wait_boards.size(), exp_wb.size()); end
      for (int i = 0; i < exp_wb.size() && i < wait_boards.size(); i++) begin
        checks++; if (wait_boards[i] !== exp_wb[i]) begin failures++; $display("FAIL rnd%0d_wait_board%0d got=%h exp=%h", s, i, wait_boards[i], exp_wb[i]); end
        checks++; if (wait_turns[i] !== turn) begin failures++; $display("FAIL rnd%0d_turn%0d got=%0b exp=%0b", s, i, wait_turns[i], turn); end
      end
      $display("random %0d: cands=%0d starts=%0d best_pos=%0d best_score=%0d valid=%0b", s, n, n_starts, pos_d, score_d, valid_d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_none();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
